// File: rtl/regfile_writeback_pkg.sv
// Shared load encodings and helpers for the MEM/WB register-file write-back path.
package regfile_writeback_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  // A load is rejected if its funct3 is unknown or its offset breaks natural alignment.
  function automatic logic load_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      LB, LBU: bad = 1'b0;
      LH, LHU: bad = addr_lo[0];
      LW:      bad = (addr_lo != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/regfile_writeback_load_fifo.sv
// Load buffer for the write-back port: FIFO of {live, rd, data} with WAW kill
// and a pending-destination mask for the hazard unit.
module wb_load_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enq,
  input  logic [REG_AW-1:0]   enq_rd,
  input  logic [N-1:0]        enq_data,
  input  logic                deq,
  input  logic                kill_valid,
  input  logic [REG_AW-1:0]   kill_rd,
  output logic [CW-1:0]       count,
  output logic                head_live,
  output logic [REG_AW-1:0]   head_rd,
  output logic [N-1:0]        head_data,
  output logic [NUM_REGS-1:0] pending_mask
);

  logic [DEPTH-1:0]  live_q;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [N-1:0]      data_q [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic              enq_live;

  // A load arriving alongside a same-rd ALU write is already stale.
  assign enq_live  = !(kill_valid && (enq_rd == kill_rd));
  assign count     = count_q;
  assign head_live = live_q[head_q];
  assign head_rd   = rd_q[head_q];
  assign head_data = data_q[head_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_valid && (rd_q[i] == kill_rd)) begin
          live_q[i] <= 1'b0;
        end
      end
      if (deq) begin
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (enq) begin
        live_q[tail_q] <= enq_live;
        rd_q[tail_q]   <= enq_rd;
        data_q[tail_q] <= enq_data;
        tail_q         <= tail_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Live bits are cleared on dequeue, so live implies occupied.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_q[i] != '0)) begin
        pending_mask[rd_q[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port owner: merges ALU results with extracted/extended
// load data from a small buffer, ALU has priority.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [N-1:0]        alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [REG_AW-1:0]   ld_rd,
  input  logic [2:0]          ld_funct3,
  input  logic [1:0]          ld_addr_lo,
  input  logic [N-1:0]        ld_word,
  output logic                RegWrite,
  output logic [REG_AW-1:0]   write_reg,
  output logic [N-1:0]        write_data,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                ld_error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic              head_live;
  logic [REG_AW-1:0] head_rd;
  logic [N-1:0]      head_data;
  logic [N-1:0]      ld_shifted;
  logic [N-1:0]      ld_ext;
  logic              ld_bad;
  logic              ld_fire;
  logic              alu_win;
  logic              deq;

  // Gated by rst_n so the load source sees backpressure throughout reset.
  assign ld_ready = rst_n && (count < CW'(DEPTH));
  assign ld_fire  = ld_valid && ld_ready;
  assign ld_bad   = load_illegal(ld_funct3, ld_addr_lo);
  assign alu_win  = alu_valid && (alu_rd != '0);
  assign deq      = !alu_win && (count != '0);

  always_comb begin
    ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
    ld_ext     = ld_shifted;
    case (ld_funct3)
      LB:      ld_ext = {{(N-8){ld_shifted[7]}}, ld_shifted[7:0]};
      LBU:     ld_ext = {{(N-8){1'b0}}, ld_shifted[7:0]};
      LH:      ld_ext = {{(N-16){ld_shifted[15]}}, ld_shifted[15:0]};
      LHU:     ld_ext = {{(N-16){1'b0}}, ld_shifted[15:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  wb_load_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq          (ld_fire && !ld_bad),
    .enq_rd       (ld_rd),
    .enq_data     (ld_ext),
    .deq          (deq),
    .kill_valid   (alu_win),
    .kill_rd      (alu_rd),
    .count        (count),
    .head_live    (head_live),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .pending_mask (pending_mask)
  );

  // Dead or rd=0 heads still drain, just without raising RegWrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      ld_error   <= 1'b0;
    end else begin
      ld_error <= ld_fire && ld_bad;
      if (alu_win) begin
        RegWrite   <= 1'b1;
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (deq && head_live && (head_rd != '0)) begin
        RegWrite   <= 1'b1;
        write_reg  <= head_rd;
        write_data <= head_data;
      end else begin
        RegWrite   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_regfile_writeback;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_word;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic        ld_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  logic        exp_err;
  logic [31:0] exp_mask;
  logic        exp_ready;
  logic        obs_ready;

  always #5 clk = ~clk;

  regfile_writeback #(.N(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_word(ld_word),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .ld_error(ld_error)
  );

  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                   input logic [31:0] w, output logic [31:0] v,
                                   output logic err);
    logic [31:0] s;
    int unsigned b, h;
    s = w >> (8 * lo);
    b = s % 256;
    h = s % 65536;
    v = s;
    err = 1'b0;
    case (f3)
      3'd0: v = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd4: v = 32'(b);
      3'd1: begin v = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h); err = (lo % 2) != 0; end
      3'd5: begin v = 32'(h); err = (lo % 2) != 0; end
      3'd2: err = (lo != 0);
      default: err = 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    mq.delete();
    exp_we = 1'b0; exp_reg = '0; exp_data = '0; exp_err = 1'b0; exp_mask = '0;
  endfunction

  task automatic drive_idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0;
    ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_word = 0;
  endtask

  // Drives one cycle of stimulus, advances the model, and lands #1 after the edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] v;
    logic err, hs, win;
    ent_t e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_addr_lo = lo; ld_word = w;
    #1;
    obs_ready = ld_ready;
    exp_ready = (mq.size() < DEPTH);
    hs = lv && exp_ready;
    ref_load(f3, lo, w, v, err);
    win = av && (ard != 0);
    exp_we = 1'b0;
    if (win) begin
      exp_we = 1'b1; exp_reg = ard; exp_data = ad;
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live && e.rd != 0) begin
        exp_we = 1'b1; exp_reg = e.rd; exp_data = e.data;
      end
    end
    if (hs && !err) begin
      e.rd = lrd; e.data = v; e.live = !(win && lrd == ard);
      mq.push_back(e);
    end
    exp_err = hs && err;
    exp_mask = '0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd != 0) exp_mask[mq[i].rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({RegWrite, write_reg, write_data, ld_error} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%0b reg=%0d data=%h err=%0b want all zero",
               RegWrite, write_reg, write_data, ld_error);
    end
    checks++;
    if (pending_mask !== 32'd0 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mask_ready: got mask=%h ready=%0b want 0/0", pending_mask, ld_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %0b want 1", ld_ready);
    end
    // Buffer two loads behind ALU traffic, then reset mid-stream.
    step(1, 1, 32'h1111, 1, 3, 3'd2, 0, 32'hA3A3A3A3);
    step(1, 2, 32'h2222, 1, 4, 3'd2, 0, 32'hA4A4A4A4);
    checks++;
    if (pending_mask !== 32'h18) begin
      failures++;
      $display("FAIL reset_prebuffer_mask: got %h want 00000018", pending_mask);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || pending_mask !== 32'd0 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_midstream: got we=%0b mask=%h ready=%0b want 0/0/0",
               RegWrite, pending_mask, ld_ready);
    end
    drive_idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (RegWrite !== 1'b0 || pending_mask !== 32'd0 || obs_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_discard c%0d: got we=%0b reg=%0d mask=%h ready=%0b want we=0 mask=0 ready=1",
                 k, RegWrite, write_reg, pending_mask, obs_ready);
      end
    end
  endtask

  task automatic test_extraction();
    logic [2:0]  f3s  [6];
    logic [1:0]  los  [6];
    logic [31:0] want [6];
    f3s  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1};
    los  = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2};
    want = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'h80FF7F01, 32'hFFFF80FF};
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 1, 5'(10 + k), f3s[k], los[k], 32'h80FF7F01);
      idle();
      checks++;
      if (RegWrite !== 1'b1 || write_reg !== 5'(10 + k) || write_data !== want[k]) begin
        failures++;
        $display("FAIL extract_%0d: got we=%0b reg=%0d data=%h want we=1 reg=%0d data=%h",
                 k, RegWrite, write_reg, write_data, 10 + k, want[k]);
      end
    end
  endtask

  task automatic test_latency();
    step(0, 0, 0, 1, 5, 3'd2, 0, 32'h5555_0005);
    checks++;
    if (RegWrite !== 1'b0 || pending_mask[5] !== 1'b1) begin
      failures++;
      $display("FAIL lat_t1: got we=%0b mask5=%0b want 0/1", RegWrite, pending_mask[5]);
    end
    step(1, 6, 32'h0000_0601, 0, 0, 0, 0, 0);
    checks++;
    if (RegWrite !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'h601 || pending_mask[5] !== 1'b1) begin
      failures++;
      $display("FAIL lat_t2: got we=%0b reg=%0d data=%h mask5=%0b want 1/6/601/1",
               RegWrite, write_reg, write_data, pending_mask[5]);
    end
    step(1, 6, 32'h0000_0602, 0, 0, 0, 0, 0);
    checks++;
    if (RegWrite !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'h602 || pending_mask[5] !== 1'b1) begin
      failures++;
      $display("FAIL lat_t3: got we=%0b reg=%0d data=%h mask5=%0b want 1/6/602/1",
               RegWrite, write_reg, write_data, pending_mask[5]);
    end
    idle();
    checks++;
    if (RegWrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h5555_0005 || pending_mask[5] !== 1'b0) begin
      failures++;
      $display("FAIL lat_t4: got we=%0b reg=%0d data=%h mask5=%0b want 1/5/55550005/0",
               RegWrite, write_reg, write_data, pending_mask[5]);
    end
    idle();
  endtask

  task automatic test_full();
    logic       av   [8];
    logic       lv   [8];
    logic [4:0] lrd  [8];
    logic       rdy  [8];
    logic       we   [8];
    logic [4:0] wreg [8];
    av   = '{1, 1, 1, 1, 0, 0, 0, 0};
    lv   = '{1, 1, 1, 1, 1, 1, 0, 0};
    lrd  = '{8, 9, 10, 10, 10, 10, 0, 0};
    rdy  = '{1, 1, 0, 0, 0, 1, 1, 1};
    we   = '{1, 1, 1, 1, 1, 1, 1, 0};
    wreg = '{1, 2, 3, 4, 8, 9, 10, 10};
    for (int k = 0; k < 8; k++) begin
      step(av[k], 5'(k + 1), 32'(k + 100), lv[k], lrd[k], 3'd2, 0, 32'(lrd[k]) << 8);
      checks++;
      if (obs_ready !== rdy[k]) begin
        failures++;
        $display("FAIL full_ready c%0d: got %0b want %0b", k, obs_ready, rdy[k]);
      end
      checks++;
      if (RegWrite !== we[k] || write_reg !== wreg[k] || write_data !== exp_data) begin
        failures++;
        $display("FAIL full_write c%0d: got we=%0b reg=%0d data=%h want we=%0b reg=%0d data=%h",
                 k, RegWrite, write_reg, write_data, we[k], wreg[k], exp_data);
      end
    end
  endtask

  task automatic test_waw_kill();
    int x7_writes;
    x7_writes = 0;
    step(0, 0, 0, 1, 7, 3'd2, 0, 32'hDEADBEEF);
    checks++;
    if (pending_mask[7] !== 1'b1) begin
      failures++;
      $display("FAIL waw_pending: got mask7=%0b want 1", pending_mask[7]);
    end
    step(1, 7, 32'h11, 0, 0, 0, 0, 0);
    if (RegWrite && write_reg == 5'd7) x7_writes++;
    checks++;
    if (RegWrite !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h11 || pending_mask[7] !== 1'b0) begin
      failures++;
      $display("FAIL waw_alu: got we=%0b reg=%0d data=%h mask7=%0b want 1/7/11/0",
               RegWrite, write_reg, write_data, pending_mask[7]);
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      if (RegWrite && write_reg == 5'd7) x7_writes++;
    end
    checks++;
    if (x7_writes != 1 || write_data !== 32'h11) begin
      failures++;
      $display("FAIL waw_once: got writes=%0d data=%h want 1 write of 00000011", x7_writes, write_data);
    end
    step(1, 9, 32'h22, 1, 9, 3'd2, 0, 32'h55);
    idle();
    checks++;
    if (RegWrite !== 1'b0 || write_data !== 32'h22 || pending_mask !== 32'd0) begin
      failures++;
      $display("FAIL waw_same_cycle: got we=%0b data=%h mask=%h want 0/22/0",
               RegWrite, write_data, pending_mask);
    end
  endtask

  task automatic test_errors();
    logic [2:0] f3s [3];
    logic [1:0] los [3];
    f3s = '{3'd2, 3'd3, 3'd5};
    los = '{2'd1, 2'd0, 2'd1};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 5'(11 + k), f3s[k], los[k], 32'hCAFE0000);
      checks++;
      if (obs_ready !== 1'b1 || ld_error !== 1'b1 || RegWrite !== 1'b0 || pending_mask !== 32'd0) begin
        failures++;
        $display("FAIL err_%0d_pulse: got ready=%0b err=%0b we=%0b mask=%h want 1/1/0/0",
                 k, obs_ready, ld_error, RegWrite, pending_mask);
      end
      idle();
      checks++;
      if (ld_error !== 1'b0 || RegWrite !== 1'b0) begin
        failures++;
        $display("FAIL err_%0d_after: got err=%0b we=%0b want 0/0", k, ld_error, RegWrite);
      end
    end
    // An unchanged (empty) count admits exactly two more loads.
    step(1, 1, 32'h1, 1, 13, 3'd2, 0, 32'h13);
    step(1, 2, 32'h2, 1, 14, 3'd2, 0, 32'h14);
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL err_count: got ready=%0b want 0 after two loads", ld_ready);
    end
    repeat (3) idle();
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int k = 0; k < 600; k++) begin
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2)
                                      : 3'($urandom);
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), f3,
           2'($urandom_range(0, 3)), $urandom);
      checks++;
      if (obs_ready !== exp_ready) begin
        failures++;
        $display("FAIL rnd_ready c%0d: got %0b want %0b", k, obs_ready, exp_ready);
      end
      checks++;
      if (RegWrite !== exp_we || write_reg !== exp_reg || write_data !== exp_data) begin
        failures++;
        $display("FAIL rnd_write c%0d: got we=%0b reg=%0d data=%h want we=%0b reg=%0d data=%h",
                 k, RegWrite, write_reg, write_data, exp_we, exp_reg, exp_data);
      end
      checks++;
      if (ld_error !== exp_err || pending_mask !== exp_mask) begin
        failures++;
        $display("FAIL rnd_err_mask c%0d: got err=%0b mask=%h want err=%0b mask=%h",
                 k, ld_error, pending_mask, exp_err, exp_mask);
      end
    end
    repeat (4) idle();
  endtask

  initial begin
    test_reset();
    test_extraction();
    test_latency();
    test_full();
    test_waw_kill();
    test_errors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
